// File: rtl/pcie_link_led_monitor.sv
// Link-status and activity LED driver for the XDMA user clock domain.
// Debounces user_lnk_up, counts qualified link events, and drives one LED.
module pcie_link_led_monitor #(
   parameter int unsigned DEBOUNCE_CYCLES    = 16,
   parameter int unsigned BLINK_HALF_CYCLES  = 62_500_000,
   parameter int unsigned ACT_STRETCH_CYCLES = 12_500_000,
   parameter int unsigned CNT_WIDTH          = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_lnk_up,
   input  logic                 i_activity,
   input  logic [1:0]           i_mode,
   input  logic                 i_clr_cnt,
   output logic                 o_led,
   output logic                 o_lnk_stable,
   output logic [CNT_WIDTH-1:0] o_lnk_up_cnt,
   output logic [CNT_WIDTH-1:0] o_lnk_down_cnt,
   output logic                 o_err_flap
);

   localparam int unsigned QW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned BW = $clog2(BLINK_HALF_CYCLES);
   localparam int unsigned AW = $clog2(ACT_STRETCH_CYCLES + 1);

   typedef enum logic [1:0] {
      LINK_DOWN = 2'd0,
      QUAL_UP   = 2'd1,
      LINK_UP   = 2'd2,
      QUAL_DOWN = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [QW-1:0]        qual_q, qual_d;
   logic                 stable_q, stable_d;
   logic [CNT_WIDTH-1:0] up_cnt_q, up_cnt_d;
   logic [CNT_WIDTH-1:0] dn_cnt_q, dn_cnt_d;
   logic                 flap_q, flap_d;
   logic [BW-1:0]        blink_q, blink_d;
   logic                 phase_q, phase_d;
   logic [AW-1:0]        act_cnt_q, act_cnt_d;
   logic                 led_q, led_d;
   logic                 up_evt, dn_evt, act;

   // Debounce FSM: a state change needs DEBOUNCE_CYCLES consecutive opposite samples
   always_comb begin
      state_d = state_q;
      qual_d  = qual_q;
      up_evt  = 1'b0;
      dn_evt  = 1'b0;
      case (state_q)
         LINK_DOWN: begin
            if (i_lnk_up) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = LINK_UP;
                  qual_d  = '0;
                  up_evt  = 1'b1;
               end else begin
                  state_d = QUAL_UP;
                  qual_d  = QW'(1);
               end
            end
         end
         QUAL_UP: begin
            if (!i_lnk_up) begin
               state_d = LINK_DOWN;
               qual_d  = '0;
            end else if (qual_q == QW'(DEBOUNCE_CYCLES - 1)) begin
               state_d = LINK_UP;
               qual_d  = '0;
               up_evt  = 1'b1;
            end else begin
               qual_d = qual_q + QW'(1);
            end
         end
         LINK_UP: begin
            if (!i_lnk_up) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = LINK_DOWN;
                  qual_d  = '0;
                  dn_evt  = 1'b1;
               end else begin
                  state_d = QUAL_DOWN;
                  qual_d  = QW'(1);
               end
            end
         end
         QUAL_DOWN: begin
            if (i_lnk_up) begin
               state_d = LINK_UP;
               qual_d  = '0;
            end else if (qual_q == QW'(DEBOUNCE_CYCLES - 1)) begin
               state_d = LINK_DOWN;
               qual_d  = '0;
               dn_evt  = 1'b1;
            end else begin
               qual_d = qual_q + QW'(1);
            end
         end
         default: begin
            state_d = LINK_DOWN;
            qual_d  = '0;
         end
      endcase
      stable_d = (state_d == LINK_UP) || (state_d == QUAL_DOWN);
   end

   // Event counters: clear takes effect first, then a saturating increment
   always_comb begin
      up_cnt_d = i_clr_cnt ? '0 : up_cnt_q;
      dn_cnt_d = i_clr_cnt ? '0 : dn_cnt_q;
      flap_d   = (i_clr_cnt ? 1'b0 : flap_q) | dn_evt;
      if (up_evt && (up_cnt_d != '1)) begin
         up_cnt_d = up_cnt_d + CNT_WIDTH'(1);
      end
      if (dn_evt && (dn_cnt_d != '1)) begin
         dn_cnt_d = dn_cnt_d + CNT_WIDTH'(1);
      end
   end

   // Free-running blink timer and activity stretcher
   always_comb begin
      blink_d   = blink_q + BW'(1);
      phase_d   = phase_q;
      if (blink_q == BW'(BLINK_HALF_CYCLES - 1)) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end
      act_cnt_d = act_cnt_q;
      if (i_activity) begin
         act_cnt_d = AW'(ACT_STRETCH_CYCLES);
      end else if (act_cnt_q != '0) begin
         act_cnt_d = act_cnt_q - AW'(1);
      end
   end

   assign act = (act_cnt_q != '0);

   // LED function uses the registered terms, giving one cycle of latency
   always_comb begin
      led_d = 1'b0;
      case (i_mode)
         2'd0:    led_d = stable_q;
         2'd1:    led_d = stable_q & (~act | phase_q);
         2'd2:    led_d = stable_q & phase_q;
         default: led_d = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= LINK_DOWN;
         qual_q    <= '0;
         stable_q  <= 1'b0;
         up_cnt_q  <= '0;
         dn_cnt_q  <= '0;
         flap_q    <= 1'b0;
         blink_q   <= '0;
         phase_q   <= 1'b0;
         act_cnt_q <= '0;
         led_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         qual_q    <= qual_d;
         stable_q  <= stable_d;
         up_cnt_q  <= up_cnt_d;
         dn_cnt_q  <= dn_cnt_d;
         flap_q    <= flap_d;
         blink_q   <= blink_d;
         phase_q   <= phase_d;
         act_cnt_q <= act_cnt_d;
         led_q     <= led_d;
      end
   end

   assign o_led          = led_q;
   assign o_lnk_stable   = stable_q;
   assign o_lnk_up_cnt   = up_cnt_q;
   assign o_lnk_down_cnt = dn_cnt_q;
   assign o_err_flap     = flap_q;

endmodule

// File: tb/tb_pcie_link_led_monitor.sv
// Self-checking bench for pcie_link_led_monitor: vector table, directed corner
// sequences and randomized traffic against a run-length reference model.
module tb_pcie_link_led_monitor;

   localparam int unsigned D  = 4;
   localparam int unsigned BH = 8;
   localparam int unsigned A  = 20;
   localparam int unsigned CW = 4;
   localparam int          CMAX = 15;

   logic          i_clk = 1'b0;
   logic          i_rstn = 1'b0;
   logic          i_lnk_up = 1'b0;
   logic          i_activity = 1'b0;
   logic [1:0]    i_mode = 2'd0;
   logic          i_clr_cnt = 1'b0;
   logic          o_led;
   logic          o_lnk_stable;
   logic [CW-1:0] o_lnk_up_cnt;
   logic [CW-1:0] o_lnk_down_cnt;
   logic          o_err_flap;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_edges, m_last_act, m_run, m_up, m_dn;
   bit m_stable, m_flap, m_led;

   pcie_link_led_monitor #(
      .DEBOUNCE_CYCLES   (D),
      .BLINK_HALF_CYCLES (BH),
      .ACT_STRETCH_CYCLES(A),
      .CNT_WIDTH         (CW)
   ) dut (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_lnk_up      (i_lnk_up),
      .i_activity    (i_activity),
      .i_mode        (i_mode),
      .i_clr_cnt     (i_clr_cnt),
      .o_led         (o_led),
      .o_lnk_stable  (o_lnk_stable),
      .o_lnk_up_cnt  (o_lnk_up_cnt),
      .o_lnk_down_cnt(o_lnk_down_cnt),
      .o_err_flap    (o_err_flap)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act_v, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_edges = 0; m_last_act = -1; m_run = 0; m_up = 0; m_dn = 0;
      m_stable = 1'b0; m_flap = 1'b0; m_led = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs the DUT is about to sample
   task automatic model_edge();
      bit ph, ac, up_e, dn_e;
      ph = ((m_edges / BH) % 2) == 1;
      ac = (m_last_act >= 0) && ((m_edges - m_last_act) < A);
      case (i_mode)
         2'd0:    m_led = m_stable;
         2'd1:    m_led = m_stable & (!ac | ph);
         2'd2:    m_led = m_stable & ph;
         default: m_led = 1'b0;
      endcase
      m_edges++;
      if (i_activity) m_last_act = m_edges;
      up_e = 1'b0; dn_e = 1'b0;
      if (i_lnk_up != m_stable) begin
         m_run++;
         if (m_run == D) begin
            m_stable = i_lnk_up;
            m_run = 0;
            if (i_lnk_up) up_e = 1'b1; else dn_e = 1'b1;
         end
      end else begin
         m_run = 0;
      end
      if (i_clr_cnt) begin m_up = 0; m_dn = 0; m_flap = 1'b0; end
      if (up_e && m_up < CMAX) m_up++;
      if (dn_e && m_dn < CMAX) m_dn++;
      if (dn_e) m_flap = 1'b1;
   endtask

   task automatic step();
      model_edge();
      @(posedge i_clk);
      #1;
      chk("model_led",    32'(o_led),          32'(m_led));
      chk("model_stable", 32'(o_lnk_stable),   32'(m_stable));
      chk("model_up_cnt", 32'(o_lnk_up_cnt),   32'(m_up));
      chk("model_dn_cnt", 32'(o_lnk_down_cnt), 32'(m_dn));
      chk("model_flap",   32'(o_err_flap),     32'(m_flap));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   typedef struct {
      logic       lnk;
      logic       exp_stable;
      logic       exp_led;
      logic [3:0] exp_up;
   } vec_t;

   vec_t tv[16];
   int   toggles;
   logic prev_led;

   initial begin
      // edge k = index+1; link rises at edge 10, stable after 13, LED after 14
      for (int i = 0; i < 16; i++) begin
         tv[i].lnk        = (i + 1 >= 10);
         tv[i].exp_stable = (i + 1 >= 13);
         tv[i].exp_led    = (i + 1 >= 14);
         tv[i].exp_up     = (i + 1 >= 13) ? 4'd1 : 4'd0;
      end

      model_reset();
      i_rstn = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset_led",    32'(o_led), 0);
      chk("reset_stable", 32'(o_lnk_stable), 0);
      chk("reset_up",     32'(o_lnk_up_cnt), 0);
      chk("reset_dn",     32'(o_lnk_down_cnt), 0);
      chk("reset_flap",   32'(o_err_flap), 0);
      i_rstn = 1'b1;

      // Test 1: table-driven link-up qualification
      for (int i = 0; i < 16; i++) begin
         i_lnk_up = tv[i].lnk;
         step();
         chk("tv_stable", 32'(o_lnk_stable), 32'(tv[i].exp_stable));
         chk("tv_led",    32'(o_led),        32'(tv[i].exp_led));
         chk("tv_up_cnt", 32'(o_lnk_up_cnt), 32'(tv[i].exp_up));
         chk("tv_dn_cnt", 32'(o_lnk_down_cnt), 0);
      end

      // Test 3: short drop ignored, full-length drop counted, then clear
      i_lnk_up = 1'b0; steps(3);
      i_lnk_up = 1'b1; step();
      chk("drop3_stable", 32'(o_lnk_stable), 1);
      chk("drop3_dn",     32'(o_lnk_down_cnt), 0);
      i_lnk_up = 1'b0; steps(3);
      chk("drop4_pre_stable", 32'(o_lnk_stable), 1);
      step();
      chk("drop4_stable", 32'(o_lnk_stable), 0);
      chk("drop4_dn",     32'(o_lnk_down_cnt), 1);
      chk("drop4_flap",   32'(o_err_flap), 1);
      i_clr_cnt = 1'b1; step(); i_clr_cnt = 1'b0;
      chk("clr_up",   32'(o_lnk_up_cnt), 0);
      chk("clr_dn",   32'(o_lnk_down_cnt), 0);
      chk("clr_flap", 32'(o_err_flap), 0);

      // Test 2: 3-cycle glitches never qualify
      for (int r = 0; r < 4; r++) begin
         i_lnk_up = 1'b1; steps(3);
         i_lnk_up = 1'b0; steps(5);
      end
      chk("glitch_stable", 32'(o_lnk_stable), 0);
      chk("glitch_led",    32'(o_led), 0);
      chk("glitch_up",     32'(o_lnk_up_cnt), 0);

      // Test 4: heartbeat, activity blink, off
      i_lnk_up = 1'b1; steps(6);
      i_mode = 2'd2; step();
      toggles = 0; prev_led = o_led;
      for (int i = 0; i < 32; i++) begin
         step();
         if (o_led != prev_led) toggles++;
         prev_led = o_led;
      end
      chk("heartbeat_toggles", 32'(toggles), 4);
      i_mode = 2'd1; i_activity = 1'b1; step(); i_activity = 1'b0;
      steps(24);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("act_done_led", 32'(o_led), 1);
      end
      i_mode = 2'd3; steps(2);
      chk("mode_off_led", 32'(o_led), 0);
      i_mode = 2'd0;

      // Test 5: saturation, then clear coincident with an up-qualifying edge
      for (int r = 0; r < 17; r++) begin
         i_lnk_up = 1'b0; steps(D);
         i_lnk_up = 1'b1; steps(D);
      end
      chk("sat_up", 32'(o_lnk_up_cnt), 15);
      chk("sat_dn", 32'(o_lnk_down_cnt), 15);
      i_lnk_up = 1'b0; steps(D);
      i_lnk_up = 1'b1; steps(D - 1);
      i_clr_cnt = 1'b1; step(); i_clr_cnt = 1'b0;
      chk("clr_coinc_up",   32'(o_lnk_up_cnt), 1);
      chk("clr_coinc_dn",   32'(o_lnk_down_cnt), 0);
      chk("clr_coinc_flap", 32'(o_err_flap), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) i_lnk_up = ~i_lnk_up;
         i_activity = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) i_mode = 2'($urandom_range(0, 3));
         i_clr_cnt = ($urandom_range(0, 99) == 0);
         step();
      end
      i_activity = 1'b0; i_clr_cnt = 1'b0; i_mode = 2'd0;

      // Test 6: asynchronous reset in LINK_UP, then requalification
      i_lnk_up = 1'b1; steps(D + 2);
      chk("pre_rst_stable", 32'(o_lnk_stable), 1);
      #3 i_rstn = 1'b0;
      #1;
      chk("async_rst_led",    32'(o_led), 0);
      chk("async_rst_stable", 32'(o_lnk_stable), 0);
      chk("async_rst_up",     32'(o_lnk_up_cnt), 0);
      chk("async_rst_dn",     32'(o_lnk_down_cnt), 0);
      chk("async_rst_flap",   32'(o_err_flap), 0);
      model_reset();
      #1 i_rstn = 1'b1;
      steps(D - 1);
      chk("requal_pre_stable", 32'(o_lnk_stable), 0);
      step();
      chk("requal_stable", 32'(o_lnk_stable), 1);
      chk("requal_up",     32'(o_lnk_up_cnt), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
